dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 12, meaning the data memory word-address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning the data width.
REQ-003 The block SHALL have parameter MAX_BURST, default 8, meaning the maximum consecutive locked grants to one port.
REQ-004 The block SHALL have these ports, one clock, reset asynchronous and active-high:
 clk  in  1  clock, all state on rising edge
 rst  in  1  asynchronous active-high reset
 pN_req  in  1  port N access request (N=0,1)
 pN_we  in  1  port N write (1) / read (0)
 pN_lock  in  1  port N requests to keep the grant next cycle
 pN_addr  in  AW  port N word address
 pN_wdata  in  DW  port N write data
 pN_gnt  out  1  port N access performed this cycle
 pN_rvalid  out  1  port N read data valid
 pN_rdata  out  DW  port N registered read data
 mem_a  out  AW  memory address
 mem_wd  out  DW  memory write data
 mem_we  out  1  memory write enable
 mem_rd  in  DW  memory combinational read data

Function
REQ-005 The block SHALL grant at most one port per cycle; pN_gnt SHALL be combinational from the requests and the arbitration state and SHALL be 0 when pN_req=0.
REQ-006 The block SHALL drive mem_a/mem_wd from the granted port and mem_we=pN_we&pN_gnt; with no grant, mem_we=0, mem_a=0 and mem_wd=0.
REQ-007 A granted write SHALL complete at the same rising edge; a granted read SHALL load mem_rd into pN_rdata at that edge and set pN_rvalid=1 for exactly the following cycle (latency 1).
REQ-008 pN_rdata SHALL hold its value until the next granted read on port N.
REQ-009 The arbitration state SHALL be: OWNER in {NONE,P0,P1}, LAST in {P0,P1}, and burst counter BCNT (width clog2(MAX_BURST)+1).
REQ-010 With OWNER=NONE and both requesting, the port selected by the priority rule (REQ-020/021) SHALL win; with one requesting, that port SHALL win.
REQ-011 After a grant to port N with pN_lock=1, OWNER SHALL become PN and BCNT SHALL increment; with pN_lock=0, OWNER SHALL become NONE and BCNT SHALL clear.
REQ-012 With OWNER=PN and pN_req=1, port N SHALL be granted regardless of the other port's request.
REQ-013 With OWNER=PN and pN_req=0, the lock SHALL be released in that same cycle and normal arbitration (REQ-010) SHALL apply.
REQ-014 When BCNT reaches MAX_BURST and the other port is requesting, the owner SHALL be refused for one cycle, the other port SHALL be granted, and BCNT SHALL clear.
REQ-015 When BCNT reaches MAX_BURST and the other port is idle, the owner SHALL keep the grant and BCNT SHALL saturate at MAX_BURST.
REQ-016 LAST SHALL be updated to the granted port on every grant.
REQ-017 pN_addr, pN_we and pN_wdata SHALL be held stable by requesters while pN_req=1 and pN_gnt=0.

Reset
REQ-018 Asserting rst SHALL immediately force OWNER=NONE, LAST=P1, BCNT=0, p0_rvalid=p1_rvalid=0 and p0_rdata=p1_rdata=0.
REQ-019 A read granted in the cycle rst asserts SHALL produce no rvalid; a write whose edge coincides with rst SHALL not be guaranteed, and mem_we SHALL be 0 while rst=1.

Configuration
REQ-020 With DMEM_ARB_RR_EN defined, the priority rule SHALL be round-robin: the port not equal to LAST wins a tie.
REQ-021 Without DMEM_ARB_RR_EN, the priority rule SHALL be fixed: port 0 always wins a tie; LAST SHALL still be maintained.

Verification
REQ-022 The bench SHALL check: p0 write addr 0x010 data 0xDEADBEEF, then p1 read 0x010 -> p1_gnt=1, p1_rvalid=1 next cycle, p1_rdata=0xDEADBEEF.
REQ-023 The bench SHALL check: both request for 4 cycles, no lock -> RR: grants alternate P0,P1,P0,P1; fixed: P0 x4, P1 none.
REQ-024 The bench SHALL check: p0 locked burst of 12 reads with p1 requesting (MAX_BURST=8) -> P0 x8, P1 x1, then P0 resumes.
REQ-025 The bench SHALL check: p1 locked, p1_req drops while p0 requests -> p0_gnt=1 in that same cycle.
REQ-026 The bench SHALL check: rst pulsed mid-burst during a read grant -> no rvalid, OWNER=NONE, rdata=0, mem_we=0 during rst.
REQ-027 The bench SHALL check: simultaneous p0 write and p1 read to the same address 0x3FF -> only the winner is performed; the loser performs it next cycle, and the read returns post-write data if the write won.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- two-port arbiter in front of a single-port data memory.
//
// Each cycle at most one port is granted. The granted port drives the
// memory address, write data and write enable. Writes complete at the
// granting edge. Reads capture the combinational memory data at that
// edge and raise rvalid for the following cycle. A port can hold the
// grant with pN_lock. A lock is cut for one cycle after MAX_BURST
// consecutive locked grants, but only if the other port is waiting.
//
// Optional feature macro: DMEM_ARB_RR_EN
//   defined   -> ties go round-robin (the port that was not granted last wins)
//   undefined -> ties go to port 0; LAST is still tracked
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pN_req/we/lock           port N request, write flag, lock-next-cycle
//   pN_addr/wdata            port N word address and write data
//   pN_gnt                   port N access performed this cycle (comb)
//   pN_rvalid/rdata          port N registered read response
//   mem_a/mem_wd/mem_we      memory address, write data, write enable
//   mem_rd                   memory combinational read data
module dmem_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic          p0_lock,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic          p1_lock,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);

  localparam int            BW   = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_t;
  typedef enum logic       {LAST_P0, LAST_P1}         last_t;

  owner_t        r_owner;
  owner_t        w_owner_nxt;
  last_t         r_last;
  logic [BW-1:0] r_bcnt;
  logic [BW-1:0] w_bcnt_nxt;

  logic w_full;
  logic w_tie_p1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_refuse;
  logic w_we;

  // Grant selection
  always_comb begin
    w_full = (r_bcnt >= BMAX);
`ifdef DMEM_ARB_RR_EN
    w_tie_p1 = (r_last == LAST_P0);
`else
    // LAST is tracked but does not affect fixed priority
    w_tie_p1 = (r_last == LAST_P0) & 1'b0;
`endif
    w_gnt0   = 1'b0;
    w_gnt1   = 1'b0;
    w_refuse = 1'b0;
    if (r_owner == OWN_P0 && p0_req) begin
      // A saturated owner gives way for one cycle only if the other port is waiting
      if (w_full && p1_req) begin
        w_gnt1   = 1'b1;
        w_refuse = 1'b1;
      end else begin
        w_gnt0 = 1'b1;
      end
    end else if (r_owner == OWN_P1 && p1_req) begin
      if (w_full && p0_req) begin
        w_gnt0   = 1'b1;
        w_refuse = 1'b1;
      end else begin
        w_gnt1 = 1'b1;
      end
    end else if (p0_req && p1_req) begin
      w_gnt1 = w_tie_p1;
      w_gnt0 = ~w_tie_p1;
    end else begin
      w_gnt0 = p0_req;
      w_gnt1 = p1_req;
    end
  end

  // Next ownership and burst count. A lock that starts on a new owner
  // counts from 1; continuing locks saturate at MAX_BURST.
  always_comb begin
    w_owner_nxt = OWN_NONE;
    w_bcnt_nxt  = '0;
    if (w_gnt0 && p0_lock) begin
      w_owner_nxt = OWN_P0;
      if (w_refuse)                w_bcnt_nxt = '0;
      else if (r_owner != OWN_P0)  w_bcnt_nxt = BW'(1);
      else if (w_full)             w_bcnt_nxt = r_bcnt;
      else                         w_bcnt_nxt = r_bcnt + BW'(1);
    end else if (w_gnt1 && p1_lock) begin
      w_owner_nxt = OWN_P1;
      if (w_refuse)                w_bcnt_nxt = '0;
      else if (r_owner != OWN_P1)  w_bcnt_nxt = BW'(1);
      else if (w_full)             w_bcnt_nxt = r_bcnt;
      else                         w_bcnt_nxt = r_bcnt + BW'(1);
    end
  end

  // Memory-side mux
  always_comb begin
    mem_a  = '0;
    mem_wd = '0;
    w_we   = 1'b0;
    if (w_gnt0) begin
      mem_a  = p0_addr;
      mem_wd = p0_wdata;
      w_we   = p0_we;
    end else if (w_gnt1) begin
      mem_a  = p1_addr;
      mem_wd = p1_wdata;
      w_we   = p1_we;
    end
  end

  assign mem_we = w_we & ~rst;
  assign p0_gnt = w_gnt0;
  assign p1_gnt = w_gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner   <= OWN_NONE;
      r_last    <= LAST_P1;
      r_bcnt    <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      r_owner   <= w_owner_nxt;
      r_bcnt    <= w_bcnt_nxt;
      if (w_gnt0)      r_last <= LAST_P0;
      else if (w_gnt1) r_last <= LAST_P1;
      p0_rvalid <= w_gnt0 & ~p0_we;
      p1_rvalid <= w_gnt1 & ~p1_we;
      if (w_gnt0 && !p0_we) p0_rdata <= mem_rd;
      if (w_gnt1 && !p1_we) p1_rdata <= mem_rd;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter. The bench provides a behavioural memory and
// keeps its own reference copy of that memory. Each driven cycle pushes the
// expected rvalid and rdata for both ports. A monitor pops one entry per
// clock edge and compares it with the DUT outputs.
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p0_lock;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_gnt, p0_rvalid;
  logic [DW-1:0] p0_rdata;
  logic          p1_req, p1_we, p1_lock;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_gnt, p1_rvalid;
  logic [DW-1:0] p1_rdata;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic          mem_we;
  logic [DW-1:0] mem_rd;

  logic [DW-1:0] env_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] hold0, hold1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic          rv0;
    logic [DW-1:0] d0;
    logic          rv1;
    logic [DW-1:0] d1;
  } sb_t;
  sb_t sb_q[$];
  sb_t mon_e;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_lock   (p0_lock),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_lock   (p1_lock),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = env_mem[mem_a];
  always @(posedge clk) if (mem_we) env_mem[mem_a] <= mem_wd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle at the falling edge and check the combinational
  // outputs. Then queue the read response expected one edge later.
  task automatic drive_cycle(input string tag,
      input logic r0, input logic w0, input logic l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
      input logic r1, input logic w1, input logic l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
      input logic eg0, input logic eg1, input logic rst_mid);
    sb_t           e;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ewe;
    p0_req = r0; p0_we = w0; p0_lock = l0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_lock = l1; p1_addr = a1; p1_wdata = d1;
    #1;
    check_eq({tag, ".g0"}, 64'(p0_gnt), 64'(eg0));
    check_eq({tag, ".g1"}, 64'(p1_gnt), 64'(eg1));
    ea  = eg0 ? a0 : (eg1 ? a1 : '0);
    ed  = eg0 ? d0 : (eg1 ? d1 : '0);
    ewe = (eg0 & w0) | (eg1 & w1);
    check_eq({tag, ".mem_a"},  64'(mem_a),  64'(ea));
    check_eq({tag, ".mem_wd"}, 64'(mem_wd), 64'(ed));
    if (rst_mid) begin
      rst = 1'b1;
      #1;
      check_eq({tag, ".rst_rv0"}, 64'(p0_rvalid), 64'(0));
      check_eq({tag, ".rst_rv1"}, 64'(p1_rvalid), 64'(0));
      check_eq({tag, ".rst_rd0"}, 64'(p0_rdata),  64'(0));
      check_eq({tag, ".rst_rd1"}, 64'(p1_rdata),  64'(0));
    end
    check_eq({tag, ".mem_we"}, 64'(mem_we), rst ? 64'(0) : 64'(ewe));
    if (rst) begin
      hold0 = '0; hold1 = '0;
      e.rv0 = 1'b0; e.rv1 = 1'b0;
    end else begin
      e.rv0 = eg0 & ~w0;
      e.rv1 = eg1 & ~w1;
      if (e.rv0) hold0 = ref_mem[a0];
      if (e.rv1) hold1 = ref_mem[a1];
      if (eg0 & w0) ref_mem[a0] = d0;
      if (eg1 & w1) ref_mem[a1] = d1;
    end
    e.d0 = hold0;
    e.d1 = hold1;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive_cycle("idle", 0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0, 0, 0);
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check_eq("sb.rv0", 64'(p0_rvalid), 64'(mon_e.rv0));
        check_eq("sb.rd0", 64'(p0_rdata),  64'(mon_e.d0));
        check_eq("sb.rv1", 64'(p1_rvalid), 64'(mon_e.rv1));
        check_eq("sb.rd1", 64'(p1_rdata),  64'(mon_e.d1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int   k0;
    logic e0, e1;
    for (int unsigned i = 0; i < (1 << AW); i++) begin
      env_mem[i[AW-1:0]] = 32'h5A000000 ^ (i * 32'h00010003);
      ref_mem[i[AW-1:0]] = 32'h5A000000 ^ (i * 32'h00010003);
    end
    hold0 = '0; hold1 = '0;
    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
    repeat (2) @(negedge clk);

    check_eq("reset.rv0",    64'(p0_rvalid), 64'(0));
    check_eq("reset.rv1",    64'(p1_rvalid), 64'(0));
    check_eq("reset.rd0",    64'(p0_rdata),  64'(0));
    check_eq("reset.rd1",    64'(p1_rdata),  64'(0));
    check_eq("reset.mem_we", 64'(mem_we),    64'(0));
    check_eq("reset.mem_a",  64'(mem_a),     64'(0));
    rst = 1'b0;

    // Write then read back through the other port
    drive_cycle("wr010", 1, 1, 0, 12'h010, 32'hDEADBEEF, 0, 0, 0, '0, '0, 1, 0, 0);
    drive_cycle("rd010", 0, 0, 0, '0, '0, 1, 0, 0, 12'h010, '0, 0, 1, 0);
    check_eq("rd010.rvalid", 64'(p1_rvalid), 64'(1));
    check_eq("rd010.rdata",  64'(p1_rdata),  64'(32'hDEADBEEF));

    // Unlocked tie for four cycles
    k0 = 0;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      e0 = (i % 2 == 0);
`else
      e0 = 1'b1;
`endif
      e1 = ~e0;
      drive_cycle("tie", 1, 0, 0, AW'(12'h100 + i), '0, 1, 0, 0, AW'(12'h200 + k0), '0, e0, e1, 0);
      if (e1) k0++;
    end
`ifndef DMEM_ARB_RR_EN
    drive_cycle("tie_p1", 0, 0, 0, '0, '0, 1, 0, 0, 12'h200, '0, 0, 1, 0);
`endif

    // Locked burst of 12 reads on p0, p1 waiting with a single read
    k0 = 0;
    for (int c = 0; c < 13; c++) begin
      e1 = (c == 8);
      e0 = ~e1;
      drive_cycle("burst", 1, 0, (k0 < 11), AW'(12'h300 + k0), '0,
                  (c <= 8), 0, 0, 12'h2F0, '0, e0, e1, 0);
      if (e0) k0++;
    end

    // Burst counter saturates while p1 is idle, then p1 gets in at once
    for (int c = 0; c < 12; c++) begin
      e1 = (c == 10);
      e0 = ~e1;
      drive_cycle("sat", 1, 0, (c < 11), AW'(12'h400 + ((c < 10) ? c : 10)), '0,
                  (c == 10), 0, 0, 12'h2F1, '0, e0, e1, 0);
    end

    // p1 owner drops its request: p0 is granted in the same cycle
    drive_cycle("lk1_a", 0, 0, 0, '0, '0,      1, 0, 1, 12'h500, '0, 0, 1, 0);
    drive_cycle("lk1_b", 1, 0, 0, 12'h501, '0, 1, 0, 1, 12'h502, '0, 0, 1, 0);
    drive_cycle("lk1_c", 1, 0, 0, 12'h501, '0, 0, 0, 0, '0,      '0, 1, 0, 0);

    // Reset pulse in the middle of a p1 locked read burst
    drive_cycle("rb0", 0, 0, 0, '0, '0, 1, 0, 1, 12'h600, '0, 0, 1, 0);
    drive_cycle("rb1", 0, 0, 0, '0, '0, 1, 0, 1, 12'h601, '0, 0, 1, 0);
    drive_cycle("rb2", 0, 0, 0, '0, '0, 1, 0, 1, 12'h602, '0, 0, 1, 1);
    drive_cycle("rbw", 1, 1, 0, 12'h050, 32'hBADC0FFE, 0, 0, 0, '0, '0, 1, 0, 0);
    rst = 1'b0;
    drive_cycle("rb_own", 1, 0, 0, 12'h050, '0, 1, 0, 1, 12'h603, '0, 1, 0, 0);
    drive_cycle("rb_p1",  0, 0, 0, '0, '0,      1, 0, 0, 12'h603, '0, 0, 1, 0);

    // Same-address conflicts at 0x3FF
    drive_cycle("c_wr",  1, 1, 0, 12'h3FF, 32'h12345678, 1, 0, 0, 12'h3FF, '0, 1, 0, 0);
    drive_cycle("c_rd",  0, 0, 0, '0, '0,                1, 0, 0, 12'h3FF, '0, 0, 1, 0);
    check_eq("c_rd.rdata", 64'(p1_rdata), 64'(32'h12345678));
    drive_cycle("c2_rd", 1, 0, 0, 12'h3FF, '0, 1, 1, 0, 12'h3FF, 32'hCAFEF00D, 1, 0, 0);
    drive_cycle("c2_wr", 0, 0, 0, '0, '0,      1, 1, 0, 12'h3FF, 32'hCAFEF00D, 0, 1, 0);
    drive_cycle("c3_rd", 1, 0, 0, 12'h3FF, '0, 0, 0, 0, '0, '0, 1, 0, 0);
    check_eq("c3_rd.rdata", 64'(p0_rdata), 64'(32'hCAFEF00D));

    idle(2);
    check_eq("sb_drain", 64'(sb_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
